// File: rtl/exec_reporter.sv
// rtl/exec_reporter.sv - tracks one pass through the executable region and reports its integrity result.
// Optional failed-run counter enabled by defining EXEC_REPORTER_ABORT_CNT_EN.
module exec_reporter (
  input  logic        clk,
  input  logic        puc_rst,
  input  logic [15:0] pc,
  input  logic        exec,
  input  logic [15:0] ER_min,
  input  logic [15:0] ER_max,
  input  logic        rpt_ack,
  output logic        rpt_valid,
  output logic        rpt_ok,
  output logic        rpt_ovf,
  output logic [7:0]  rpt_runs,
  output logic [7:0]  abort_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       fail_q, fail_d;
  logic       ok_q, ok_d;
  logic       ovf_q, ovf_d;
  logic [7:0] runs_q, runs_d;

  logic range_valid;
  logic entry;
  logic in_er;

  // An inverted region can never be entered, so it also never produces a run.
  assign range_valid = (ER_min <= ER_max);
  assign entry       = range_valid && (pc == ER_min);
  assign in_er       = (pc >= ER_min) && (pc <= ER_max);

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    ok_d    = ok_q;
    ovf_d   = ovf_q;
    runs_d  = runs_q;
    case (state_q)
      IDLE: begin
        if (entry) begin
          state_d = RUN;
          fail_d  = 1'b0;
        end
      end
      RUN: begin
        if (pc == ER_max) begin
          state_d = REPORT;
          ok_d    = exec && !fail_q;
        end else if (!in_er) begin
          state_d = REPORT;
          ok_d    = 1'b0;
        end else if (!exec) begin
          fail_d  = 1'b1;
        end
      end
      REPORT: begin
        if (rpt_ack) begin
          runs_d = runs_q + 8'd1;
          if (entry) begin
            state_d = RUN;
            fail_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (entry) begin
          // Pending report is kept; the missed run is only flagged.
          ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (puc_rst) begin
      state_q <= IDLE;
      fail_q  <= 1'b0;
      ok_q    <= 1'b0;
      ovf_q   <= 1'b0;
      runs_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
      ok_q    <= ok_d;
      ovf_q   <= ovf_d;
      runs_q  <= runs_d;
    end
  end

  assign rpt_valid = (state_q == REPORT);
  assign rpt_ok    = ok_q;
  assign rpt_ovf   = ovf_q;
  assign rpt_runs  = runs_q;

`ifdef EXEC_REPORTER_ABORT_CNT_EN
  logic [7:0] abort_q;
  logic       abort_inc;

  assign abort_inc = (state_q == RUN) && (state_d == REPORT) && !ok_d;

  always_ff @(posedge clk) begin
    if (puc_rst) begin
      abort_q <= 8'd0;
    end else if (abort_inc && (abort_q != 8'hFF)) begin
      abort_q <= abort_q + 8'd1;
    end
  end

  assign abort_cnt = abort_q;
`else
  assign abort_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_exec_reporter.sv
// tb/tb_exec_reporter.sv - directed and randomized checks of exec_reporter against a behavioural model.
module tb_exec_reporter;

  logic        clk = 1'b0;
  logic        puc_rst = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic        exec = 1'b1;
  logic [15:0] ER_min = 16'hE000;
  logic [15:0] ER_max = 16'hE010;
  logic        rpt_ack = 1'b0;
  logic        rpt_valid;
  logic        rpt_ok;
  logic        rpt_ovf;
  logic [7:0]  rpt_runs;
  logic [7:0]  abort_cnt;

  always #5 clk = ~clk;

  exec_reporter dut (
    .clk       (clk),
    .puc_rst   (puc_rst),
    .pc        (pc),
    .exec      (exec),
    .ER_min    (ER_min),
    .ER_max    (ER_max),
    .rpt_ack   (rpt_ack),
    .rpt_valid (rpt_valid),
    .rpt_ok    (rpt_ok),
    .rpt_ovf   (rpt_ovf),
    .rpt_runs  (rpt_runs),
    .abort_cnt (abort_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

`ifdef EXEC_REPORTER_ABORT_CNT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a run is "open" between an entry and its end, a report is "pending" until acked.
  bit m_open, m_pending, m_broken, m_result, m_missed;
  int m_acks, m_failed_runs;

  always @(posedge clk) begin
    int  lo, hi, p;
    bit  entered;
    lo = int'(ER_min);
    hi = int'(ER_max);
    p  = int'(pc);
    entered = (lo <= hi) && (p == lo);
    if (puc_rst) begin
      m_open = 0; m_pending = 0; m_broken = 0; m_result = 0; m_missed = 0;
      m_acks = 0; m_failed_runs = 0;
    end else if (m_pending) begin
      if (rpt_ack) begin
        m_acks    = (m_acks + 1) % 256;
        m_pending = 0;
        if (entered) begin
          m_open = 1; m_broken = 0;
        end
      end else if (entered) begin
        m_missed = 1;
      end
    end else if (m_open) begin
      if (p == hi || p < lo || p > hi) begin
        m_open    = 0;
        m_pending = 1;
        m_result  = (p == hi) ? (exec && !m_broken) : 1'b0;
        if (!m_result && m_failed_runs < 255) m_failed_runs++;
      end else if (!exec) begin
        m_broken = 1;
      end
    end else if (entered) begin
      m_open = 1; m_broken = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_valid", int'(rpt_valid), int'(m_pending));
      if (m_pending) chk("model_ok", int'(rpt_ok), int'(m_result));
      chk("model_ovf", int'(rpt_ovf), int'(m_missed));
      chk("model_runs", int'(rpt_runs), m_acks);
      chk("model_abort", int'(abort_cnt), ABORT_EN ? m_failed_runs : 0);
    end
  end

  task automatic step(input logic [15:0] p, input logic e, input logic a);
    pc = p; exec = e; rpt_ack = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    puc_rst = 1'b1;
    step(16'h0000, 1'b1, 1'b0);
    puc_rst = 1'b0;
  endtask

  task automatic walk(input int lo, input int hi, input int bad);
    for (int p = lo; p <= hi; p++) step(16'(p), (p != bad), 1'b0);
  endtask

  initial begin
    do_reset();
    chk_en = 1;
    chk("rst_valid", int'(rpt_valid), 0);
    chk("rst_ovf", int'(rpt_ovf), 0);
    chk("rst_runs", int'(rpt_runs), 0);
    chk("rst_abort", int'(abort_cnt), 0);

    // Clean run, ack two cycles after the report appears
    walk(16'hE000, 16'hE00F, -1);
    chk("clean_not_yet", int'(rpt_valid), 0);
    step(16'hE010, 1'b1, 1'b0);
    chk("clean_valid", int'(rpt_valid), 1);
    chk("clean_ok", int'(rpt_ok), 1);
    step(16'h0000, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b1);
    chk("clean_acked", int'(rpt_valid), 0);
    chk("clean_runs", int'(rpt_runs), 1);

    // Mid-run violation
    walk(16'hE000, 16'hE010, 16'hE008);
    chk("viol_valid", int'(rpt_valid), 1);
    chk("viol_ok", int'(rpt_ok), 0);
    chk("viol_abort", int'(abort_cnt), ABORT_EN ? 1 : 0);
    step(16'h0000, 1'b1, 1'b1);

    // Early exit
    walk(16'hE000, 16'hE004, -1);
    step(16'hC000, 1'b1, 1'b0);
    chk("exit_valid", int'(rpt_valid), 1);
    chk("exit_ok", int'(rpt_ok), 0);
    step(16'h0000, 1'b1, 1'b1);
    chk("exit_runs", int'(rpt_runs), 3);

    // Overflow, then ack with simultaneous re-entry
    walk(16'hE000, 16'hE010, -1);
    step(16'hE000, 1'b1, 1'b0);
    chk("ovf_set", int'(rpt_ovf), 1);
    chk("ovf_held_valid", int'(rpt_valid), 1);
    chk("ovf_held_ok", int'(rpt_ok), 1);
    step(16'hE000, 1'b1, 1'b1);
    chk("reentry_valid", int'(rpt_valid), 0);
    chk("reentry_runs", int'(rpt_runs), 4);
    walk(16'hE001, 16'hE010, -1);
    chk("reentry_report", int'(rpt_valid), 1);
    chk("reentry_ok", int'(rpt_ok), 1);
    chk("ovf_sticky", int'(rpt_ovf), 1);
    step(16'h0000, 1'b1, 1'b1);

    // Reset mid-run discards the run
    walk(16'hE000, 16'hE005, -1);
    puc_rst = 1'b1;
    step(16'hE006, 1'b1, 1'b0);
    puc_rst = 1'b0;
    chk("rstrun_valid", int'(rpt_valid), 0);
    chk("rstrun_ovf", int'(rpt_ovf), 0);
    chk("rstrun_runs", int'(rpt_runs), 0);
    step(16'hE010, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b0);
    chk("rstrun_no_report", int'(rpt_valid), 0);

    // Inverted region never starts a run
    ER_min = 16'hE010; ER_max = 16'hE000;
    step(16'hE010, 1'b1, 1'b0);
    step(16'hC000, 1'b1, 1'b0);
    chk("inverted_idle", int'(rpt_valid), 0);

    // Single-address region: entry goes to RUN first, report one edge later
    ER_min = 16'h1234; ER_max = 16'h1234;
    step(16'h1234, 1'b1, 1'b0);
    chk("single_run", int'(rpt_valid), 0);
    step(16'h1234, 1'b1, 1'b0);
    chk("single_report", int'(rpt_valid), 1);
    chk("single_ok", int'(rpt_ok), 1);
    step(16'h0000, 1'b1, 1'b1);

    // Counter limits
    ER_min = 16'hE000; ER_max = 16'hE010;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step(16'hE000, 1'b1, 1'b0);
      step(16'hE010, 1'b1, 1'b0);
      if (i == 254) chk("runs_pre_wrap", int'(rpt_runs), 254);
      step(16'h0000, 1'b1, 1'b1);
    end
    chk("runs_wrap", int'(rpt_runs), 0);
    for (int i = 0; i < 300; i++) begin
      step(16'hE000, 1'b1, 1'b0);
      step(16'hC000, 1'b1, 1'b0);
      step(16'h0000, 1'b1, 1'b1);
    end
    chk("abort_sat", int'(abort_cnt), ABORT_EN ? 255 : 0);
    chk("runs_after_300", int'(rpt_runs), 44);

    // Randomized segments with fresh regions
    for (int seg = 0; seg < 5; seg++) begin
      int lo, span, r, pv;
      lo   = int'($urandom_range(16'h1000, 16'hF000));
      span = int'($urandom_range(0, 12));
      ER_min = 16'(lo);
      ER_max = 16'(lo + span);
      do_reset();
      for (int c = 0; c < 600; c++) begin
        r = int'($urandom_range(0, 9));
        if (r < 3)      pv = lo;
        else if (r < 5) pv = lo + span;
        else if (r < 8) pv = lo + int'($urandom_range(0, span));
        else if (r < 9) pv = lo + span + 1 + int'($urandom_range(0, 3));
        else            pv = lo - 1 - int'($urandom_range(0, 3));
        puc_rst = ($urandom_range(0, 199) == 0);
        step(16'(pv), ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0));
      end
      puc_rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_reporter.md
EXEC_REPORTER -- requirements
Module: exec_reporter

Interface
REQ-001: clk  input  1  system clock; all state updates on posedge clk.
REQ-002: puc_rst  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-003: pc  input  16  current program counter.
REQ-004: exec  input  1  execution-integrity flag from the ER monitor; 1 = run not yet violated.
REQ-005: ER_min  input  16  first address of the executable region (ER).
REQ-006: ER_max  input  16  last address of the ER.
REQ-007: rpt_ack  input  1  consumer accepts the pending report.
REQ-008: rpt_valid  output  1  a run report is pending.
REQ-009: rpt_ok  output  1  result of the reported run; 1 = run clean.
REQ-010: rpt_ovf  output  1  sticky flag: an ER entry was missed while a report was pending.
REQ-011: rpt_runs  output  8  count of acknowledged reports; wraps modulo 256.
REQ-012: abort_cnt  output  8  count of failed runs; see Configuration.

Function
REQ-013: The block SHALL implement three states: IDLE, RUN and REPORT.
REQ-014: In IDLE, pc == ER_min SHALL cause a transition to RUN on the next edge and SHALL clear the internal fail bit.
REQ-015: In RUN, a cycle with ER_min <= pc <= ER_max and exec == 0 SHALL set the fail bit.
REQ-016: In RUN, pc == ER_max SHALL cause a transition to REPORT with rpt_ok <= exec && !fail.
REQ-017: In RUN, pc outside [ER_min, ER_max] SHALL cause a transition to REPORT with rpt_ok <= 0.
REQ-018: RUN SHALL be observed for at least one cycle.
- An entry cycle where pc == ER_min == ER_max SHALL transition to RUN, not directly to REPORT.
REQ-019: rpt_valid SHALL be 1 exactly while in REPORT.
- rpt_valid SHALL assert on the edge that enters REPORT (one-cycle latency from the exit/ER_max cycle).
REQ-020: rpt_ok SHALL hold stable while rpt_valid == 1.
REQ-021: In REPORT, rpt_ack == 1 SHALL, on the next edge:
- increment rpt_runs (wrapping 255 -> 0);
- transition to IDLE, deasserting rpt_valid.
REQ-022: rpt_ack SHALL be ignored outside REPORT.
REQ-023: In REPORT, pc == ER_min with rpt_ack == 0 SHALL set rpt_ovf.
- The pending report SHALL not be overwritten, and the state SHALL remain REPORT.
REQ-024: In REPORT, pc == ER_min with rpt_ack == 1 in the same cycle SHALL:
- complete the acknowledgement (REQ-021);
- transition directly to RUN with fail cleared;
- leave rpt_ovf unchanged.
REQ-025: rpt_ovf SHALL remain set until puc_rst.
REQ-026: When ER_min > ER_max, the block SHALL remain in IDLE.
REQ-027: All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-028: puc_rst == 1 SHALL, on the next edge:
- force state to IDLE;
- clear fail, rpt_valid, rpt_ok, rpt_ovf, rpt_runs and abort_cnt.
REQ-029: Reset SHALL take priority over every other event, including mid-RUN and pending REPORT; a pending report SHALL be discarded.
REQ-030: Power-up initial values SHALL equal the reset values.

Configuration
REQ-031: Macro EXEC_REPORTER_ABORT_CNT_EN defined:
- abort_cnt SHALL increment on every edge that enters REPORT with rpt_ok == 0;
- abort_cnt SHALL saturate at 255.
REQ-032: Macro EXEC_REPORTER_ABORT_CNT_EN undefined:
- abort_cnt SHALL be constant 0;
- no counter register SHALL be synthesized.
- All other behaviour SHALL be identical in both configurations.

Verification
REQ-033: Clean run.
- Stimulus: ER=0xE000..0xE010; pc walks 0xE000->0xE010 with exec=1; ack 2 cycles after rpt_valid.
- Response: rpt_valid=1 one cycle after pc=0xE010; rpt_ok=1; rpt_runs=1 after ack.
REQ-034: Mid-run violation.
- Stimulus: same walk, exec=0 for one cycle at pc=0xE008, then exec=1.
- Response: rpt_ok=0; abort_cnt=1 with macro, 0 without.
REQ-035: Early exit.
- Stimulus: pc jumps 0xE004->0xC000.
- Response: REPORT with rpt_ok=0 on the next edge.
REQ-036: Overflow, then ack with simultaneous re-entry.
- Stimulus: report pending, no ack, pc=0xE000 → rpt_ovf=1 and rpt_ok unchanged.
- Stimulus: ack together with pc=0xE000 → state RUN next cycle, rpt_runs incremented.
REQ-037: Reset mid-RUN.
- Stimulus: assert puc_rst at pc=0xE006.
- Response: all outputs 0 next cycle; a following pc=0xE010 produces no report.
REQ-038: Counter limits.
- Stimulus: 256 acknowledged runs → rpt_runs wraps to 0.
- Stimulus: 300 failed runs with macro defined → abort_cnt=255.
